tx_frame_sequencer: RTL and testbench



---
 rtl/tx_frame_sequencer_pkg.sv | 29 ++
 rtl/tx_frame_sequencer_if.sv | 29 ++
 rtl/tx_frame_sequencer_tick_counter.sv | 31 +++
 rtl/tx_frame_sequencer.sv | 122 ++++++++++++
 tb/tb_tx_frame_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_frame_sequencer_pkg.sv
// Shared definitions for the TX frame sequencer: phase encodings, the
// per-frame configuration record and the data-bit clamping rule.
package tx_pkg;

    typedef enum logic [2:0] {
        PH_IDLE   = 3'd0,
        PH_START  = 3'd1,
        PH_DATA   = 3'd2,
        PH_PARITY = 3'd3,
        PH_STOP   = 3'd4
    } tx_phase_e;

    localparam int MIN_DATA_BITS = 5;

    // Frame format as captured at frame start; data_bits is already clamped.
    typedef struct packed {
        logic [3:0] data_bits;
        logic       parity_en;
        logic       stop2;
    } tx_cfg_t;

    // Out-of-range requests saturate to the nearest legal data-bit count.
    function automatic logic [3:0] clamp_data_bits(input logic [3:0] req, input int max_bits);
        if (int'(req) < MIN_DATA_BITS) return 4'(MIN_DATA_BITS);
        if (int'(req) > max_bits)      return 4'(max_bits);
        return req;
    endfunction

endpackage

// File: rtl/tx_frame_sequencer_if.sv
// Control/status bundle between the TX controller (master) and the frame
// sequencer (slave).
interface tx_frame_sequencer_if;
    import tx_pkg::*;

    logic       start;
    logic       abort;
    logic       tick;
    logic [3:0] cfg_data_bits;
    logic       cfg_parity_en;
    logic       cfg_stop2;

    logic       busy;
    logic [2:0] phase;
    logic [3:0] bit_idx;
    logic       bit_strobe;
    logic       done;

    modport master (
        output start, abort, tick, cfg_data_bits, cfg_parity_en, cfg_stop2,
        input  busy, phase, bit_idx, bit_strobe, done
    );

    modport slave (
        input  start, abort, tick, cfg_data_bits, cfg_parity_en, cfg_stop2,
        output busy, phase, bit_idx, bit_strobe, done
    );

endinterface

// File: rtl/tx_frame_sequencer_tick_counter.sv
// Counts baud ticks within one bit period and flags the tick that closes it.
module tx_tick_counter #(
    parameter int TICKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic clr,
    output logic bit_end
);

    localparam int            CW   = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    // bit_end is only meaningful while a frame runs; clr masks it otherwise.
    assign bit_end = tick && !clr && (r_cnt == LAST);

    // Tick counter wraps on the closing tick so the next bit starts from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tx_frame_sequencer.sv
// UART TX frame sequencer: walks START, DATA, optional PARITY and STOP bits
// from baud ticks, with the frame format latched at frame start.
module tx_frame_sequencer
    import tx_pkg::*;
#(
    parameter int DATA_BITS_MAX = 9,
    parameter int TICKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tx_frame_sequencer_if.slave  bus
);

    tx_phase_e  r_phase, w_phase_nxt;
    logic [3:0] r_bit_idx, w_bit_idx_nxt;
    logic       r_busy;
    logic       r_strobe, w_strobe_nxt;
    logic       r_done, w_done_nxt;
    logic       w_cfg_load;
    tx_cfg_t    r_cfg;
    logic       w_clr;
    logic       w_bit_end;
    logic       w_last_data;
    logic       w_last_stop;

    // Counter is held at zero whenever no frame is running or one is aborted.
    assign w_clr = (r_phase == PH_IDLE) || bus.abort;

    tx_tick_counter #(
        .TICKS_PER_BIT (TICKS_PER_BIT)
    ) u_tick_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (bus.tick),
        .clr     (w_clr),
        .bit_end (w_bit_end)
    );

    assign w_last_data = (r_bit_idx == (r_cfg.data_bits - 4'd1));
    assign w_last_stop = (r_bit_idx == {3'b000, r_cfg.stop2});

    // Next phase / bit index; abort beats tick, and start is only seen in IDLE.
    always_comb begin
        w_phase_nxt   = r_phase;
        w_bit_idx_nxt = r_bit_idx;
        w_strobe_nxt  = 1'b0;
        w_done_nxt    = 1'b0;
        w_cfg_load    = 1'b0;
        if (r_phase == PH_IDLE) begin
            if (bus.start && !bus.abort) begin
                w_phase_nxt   = PH_START;
                w_bit_idx_nxt = '0;
                w_strobe_nxt  = 1'b1;
                w_cfg_load    = 1'b1;
            end
        end else if (bus.abort) begin
            w_phase_nxt   = PH_IDLE;
            w_bit_idx_nxt = '0;
        end else if (w_bit_end) begin
            w_strobe_nxt  = 1'b1;
            w_bit_idx_nxt = '0;
            case (r_phase)
                PH_START: w_phase_nxt = PH_DATA;
                PH_DATA: begin
                    if (!w_last_data)        w_bit_idx_nxt = r_bit_idx + 4'd1;
                    else if (r_cfg.parity_en) w_phase_nxt  = PH_PARITY;
                    else                      w_phase_nxt  = PH_STOP;
                end
                PH_PARITY: w_phase_nxt = PH_STOP;
                PH_STOP: begin
                    if (w_last_stop) begin
                        w_phase_nxt  = PH_IDLE;
                        w_strobe_nxt = 1'b0;
                        w_done_nxt   = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 4'd1;
                    end
                end
                default: w_phase_nxt = PH_IDLE;
            endcase
        end
    end

    // Phase state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_phase <= PH_IDLE;
        else          r_phase <= w_phase_nxt;
    end

    // Registered status outputs derived from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_idx <= '0;
            r_busy    <= 1'b0;
            r_strobe  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_bit_idx <= w_bit_idx_nxt;
            r_busy    <= (w_phase_nxt != PH_IDLE);
            r_strobe  <= w_strobe_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Frame format is captured once at frame start and frozen until IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg <= '0;
        end else if (w_cfg_load) begin
            r_cfg.data_bits <= clamp_data_bits(bus.cfg_data_bits, DATA_BITS_MAX);
            r_cfg.parity_en <= bus.cfg_parity_en;
            r_cfg.stop2     <= bus.cfg_stop2;
        end
    end

    assign bus.busy       = r_busy;
    assign bus.phase      = r_phase;
    assign bus.bit_idx    = r_bit_idx;
    assign bus.bit_strobe = r_strobe;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Bench for tx_frame_sequencer: three instances (TICKS_PER_BIT 16, 4, 2) share
// one stimulus stream; a bit-list reference model predicts every output.
module tb_tx_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] cfg_data_bits = 4'd0;
    logic       cfg_parity_en = 1'b0;
    logic       cfg_stop2 = 1'b0;

    // {busy, phase[2:0], bit_idx[3:0], bit_strobe, done} per instance
    logic [2:0][9:0] obs;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int T = (g == 0) ? 16 : ((g == 1) ? 4 : 2);
        tx_frame_sequencer_if bus();
        assign bus.start         = start;
        assign bus.abort         = abort;
        assign bus.tick          = tick;
        assign bus.cfg_data_bits = cfg_data_bits;
        assign bus.cfg_parity_en = cfg_parity_en;
        assign bus.cfg_stop2     = cfg_stop2;
        assign obs[g] = {bus.busy, bus.phase, bus.bit_idx, bus.bit_strobe, bus.done};
        tx_frame_sequencer #(.DATA_BITS_MAX(9), .TICKS_PER_BIT(T)) u_dut (
            .clk     (clk),
            .reset_n (rst_n),
            .bus     (bus.slave)
        );
    end

    // ---------------- reference model: a frame is a list of bit slots ----------
    bit m_busy [3];
    bit m_stb  [3];
    bit m_done [3];
    int m_pos  [3];
    int m_cnt  [3];
    int m_n    [3];
    int m_par  [3];
    int m_stop [3];

    function automatic int tpb(input int d);
        return (d == 0) ? 16 : ((d == 1) ? 4 : 2);
    endfunction

    function automatic int clamp_bits(input int v);
        return (v < 5) ? 5 : ((v > 9) ? 9 : v);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_busy[d] = 0; m_stb[d] = 0; m_done[d] = 0;
            m_pos[d] = 0; m_cnt[d] = 0;
        end
    endtask

    // Advance the model over the clock edge that just happened.
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 3; d++) begin
            m_stb[d] = 0;
            m_done[d] = 0;
            if (!m_busy[d]) begin
                if (start && !abort) begin
                    m_n[d]    = clamp_bits(int'(cfg_data_bits));
                    m_par[d]  = cfg_parity_en ? 1 : 0;
                    m_stop[d] = cfg_stop2 ? 2 : 1;
                    m_busy[d] = 1; m_pos[d] = 0; m_cnt[d] = 0; m_stb[d] = 1;
                end
            end else if (abort) begin
                m_busy[d] = 0; m_cnt[d] = 0;
            end else if (tick) begin
                m_cnt[d]++;
                if (m_cnt[d] == tpb(d)) begin
                    m_cnt[d] = 0;
                    m_pos[d]++;
                    if (m_pos[d] == 1 + m_n[d] + m_par[d] + m_stop[d]) begin
                        m_busy[d] = 0; m_done[d] = 1;
                    end else begin
                        m_stb[d] = 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [9:0] expect_of(input int d);
        logic [2:0] ph;
        logic [3:0] ix;
        int p;
        p = m_pos[d];
        ph = 3'd0;
        ix = 4'd0;
        if (m_busy[d]) begin
            if (p == 0) ph = 3'd1;
            else if (p <= m_n[d]) begin ph = 3'd2; ix = 4'(p - 1); end
            else if (m_par[d] == 1 && p == m_n[d] + 1) ph = 3'd3;
            else begin ph = 3'd4; ix = 4'(p - 1 - m_n[d] - m_par[d]); end
        end
        return {m_busy[d], ph, ix, m_stb[d], m_done[d]};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        model_reset();
        tick = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (obs[d] !== 10'b0) $display("FAIL reset_value dut%0d got=%b want=0", d, obs[d]);
                else n_pass++;
            end
        end
        rst_n = 1'b1;
        // ticks while idle must not start anything
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            model_step();
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (obs[d] !== expect_of(d)) $display("FAIL idle_tick dut%0d got=%b want=%b", d, obs[d], expect_of(d));
                else n_pass++;
            end
        end
    endtask

    task automatic test_8n1();
        int strobes = 0, first_stb = -1, last_stb = -1;
        int busy_n = 0, first_busy = -1, last_busy = -1, done_n = 0, done_at = -1;
        logic [6:0] want;
        @(negedge clk);
        start = 1; abort = 0; tick = 1; cfg_data_bits = 8; cfg_parity_en = 0; cfg_stop2 = 0;
        for (int c = 1; c <= 175; c++) begin
            @(negedge clk);
            model_step();
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (obs[d] !== expect_of(d)) $display("FAIL 8n1_model dut%0d c%0d got=%b want=%b", d, c, obs[d], expect_of(d));
                else n_pass++;
            end
            if (obs[0][9]) begin busy_n++; if (first_busy < 0) first_busy = c; last_busy = c; end
            if (obs[0][1]) begin
                strobes++; if (first_stb < 0) first_stb = c; last_stb = c;
                want = (c == 1) ? 7'h10 : ((c <= 129) ? {3'd2, 4'((c - 17) / 16)} : 7'h40);
                n_total++;
                if (obs[0][8:2] !== want) $display("FAIL 8n1_phase_idx c%0d got=%h want=%h", c, obs[0][8:2], want);
                else n_pass++;
            end
            if (obs[0][0]) begin done_n++; done_at = c; end
            start = 0;
        end
        n_total++; if (strobes !== 10)     $display("FAIL 8n1_strobe_count got=%0d want=10", strobes); else n_pass++;
        n_total++; if (first_stb !== 1)    $display("FAIL 8n1_first_strobe got=%0d want=1", first_stb); else n_pass++;
        n_total++; if (last_stb !== 145)   $display("FAIL 8n1_last_strobe got=%0d want=145", last_stb); else n_pass++;
        n_total++; if (busy_n !== 160)     $display("FAIL 8n1_busy_count got=%0d want=160", busy_n); else n_pass++;
        n_total++; if (first_busy !== 1)   $display("FAIL 8n1_first_busy got=%0d want=1", first_busy); else n_pass++;
        n_total++; if (last_busy !== 160)  $display("FAIL 8n1_last_busy got=%0d want=160", last_busy); else n_pass++;
        n_total++; if (done_n !== 1)       $display("FAIL 8n1_done_count got=%0d want=1", done_n); else n_pass++;
        n_total++; if (done_at !== 161)    $display("FAIL 8n1_done_cycle got=%0d want=161", done_at); else n_pass++;
    endtask

    task automatic test_7e2();
        int busy_n = 0, last_busy = -1, par_n = 0, first_par = -1, last_par = -1, done_at = -1;
        logic [6:0] want;
        @(negedge clk);
        start = 1; abort = 0; tick = 1; cfg_data_bits = 7; cfg_parity_en = 1; cfg_stop2 = 1;
        for (int c = 1; c <= 190; c++) begin
            @(negedge clk);
            model_step();
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (obs[d] !== expect_of(d)) $display("FAIL 7e2_model dut%0d c%0d got=%b want=%b", d, c, obs[d], expect_of(d));
                else n_pass++;
            end
            if (obs[1][9]) begin busy_n++; last_busy = c; end
            if (obs[1][8:6] == 3'd3) begin par_n++; if (first_par < 0) first_par = c; last_par = c; end
            if (obs[1][0]) done_at = c;
            if (c == 37 || c == 41) begin
                want = {3'd4, 4'(c == 41)};
                n_total++;
                if (obs[1][8:2] !== want) $display("FAIL 7e2_stop_idx c%0d got=%h want=%h", c, obs[1][8:2], want);
                else n_pass++;
            end
            start = 0;
        end
        n_total++; if (busy_n !== 44)    $display("FAIL 7e2_busy_count got=%0d want=44", busy_n); else n_pass++;
        n_total++; if (last_busy !== 44) $display("FAIL 7e2_last_busy got=%0d want=44", last_busy); else n_pass++;
        n_total++; if (par_n !== 4)      $display("FAIL 7e2_parity_len got=%0d want=4", par_n); else n_pass++;
        n_total++; if (first_par !== 33) $display("FAIL 7e2_parity_first got=%0d want=33", first_par); else n_pass++;
        n_total++; if (last_par !== 36)  $display("FAIL 7e2_parity_last got=%0d want=36", last_par); else n_pass++;
        n_total++; if (done_at !== 45)   $display("FAIL 7e2_done_cycle got=%0d want=45", done_at); else n_pass++;
    endtask

    task automatic test_clamp();
        for (int part = 0; part < 2; part++) begin
            int data_n = 0, max_idx = 0, done_at = -1;
            int want_n = (part == 1) ? 9 : 5;
            int want_done = (part == 1) ? 45 : 29;
            @(negedge clk);
            start = 1; abort = 0; tick = 1; cfg_parity_en = 0; cfg_stop2 = 0;
            cfg_data_bits = (part == 1) ? 4'd12 : 4'd3;
            for (int c = 1; c <= ((part == 1) ? 190 : 130); c++) begin
                @(negedge clk);
                model_step();
                for (int d = 0; d < 3; d++) begin
                    n_total++;
                    if (obs[d] !== expect_of(d)) $display("FAIL clamp_model p%0d dut%0d c%0d got=%b want=%b", part, d, c, obs[d], expect_of(d));
                    else n_pass++;
                end
                if (obs[1][8:6] == 3'd2) begin
                    if (obs[1][1]) data_n++;
                    if (int'(obs[1][5:2]) > max_idx) max_idx = int'(obs[1][5:2]);
                end
                if (obs[1][0]) done_at = c;
                start = 0;
                // reconfigure mid-frame; the running frame must ignore it
                if (c == 10) begin cfg_data_bits = 4'd15; cfg_parity_en = 1; cfg_stop2 = 1; end
            end
            n_total++; if (data_n !== want_n)      $display("FAIL clamp_data_count p%0d got=%0d want=%0d", part, data_n, want_n); else n_pass++;
            n_total++; if (max_idx !== want_n - 1) $display("FAIL clamp_max_idx p%0d got=%0d want=%0d", part, max_idx, want_n - 1); else n_pass++;
            n_total++; if (done_at !== want_done)  $display("FAIL clamp_done_cycle p%0d got=%0d want=%0d", part, done_at, want_done); else n_pass++;
        end
    endtask

    task automatic test_slow_tick();
        int stb_n = 0, last_stb = -1, busy_n = 0, done_at = -1;
        @(negedge clk);
        start = 1; abort = 0; tick = 1; cfg_data_bits = 5; cfg_parity_en = 0; cfg_stop2 = 0;
        for (int c = 1; c <= 360; c++) begin
            @(negedge clk);
            model_step();
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (obs[d] !== expect_of(d)) $display("FAIL slow_model dut%0d c%0d got=%b want=%b", d, c, obs[d], expect_of(d));
                else n_pass++;
            end
            if (c <= 43) begin
                if (obs[2][9]) busy_n++;
                if (obs[2][0] && done_at < 0) done_at = c;
                if (obs[2][1]) begin
                    stb_n++; last_stb = c;
                    n_total++;
                    if (((c - 1) % 6) != 0) $display("FAIL slow_strobe_spacing got=%0d want=multiple of 6 after 1", c);
                    else n_pass++;
                end
            end
            if (c == 44) begin
                n_total++;
                if (obs[2][9:1] !== 9'b1_001_0000_1) $display("FAIL slow_back_to_back got=%b want=100100001", obs[2][9:1]);
                else n_pass++;
            end
            tick = ((c % 3) == 0);
            start = (c <= 43);
        end
        start = 0;
        n_total++; if (stb_n !== 7)     $display("FAIL slow_strobe_count got=%0d want=7", stb_n); else n_pass++;
        n_total++; if (last_stb !== 37) $display("FAIL slow_last_strobe got=%0d want=37", last_stb); else n_pass++;
        n_total++; if (busy_n !== 42)   $display("FAIL slow_busy_count got=%0d want=42", busy_n); else n_pass++;
        n_total++; if (done_at !== 43)  $display("FAIL slow_done_cycle got=%0d want=43", done_at); else n_pass++;
    endtask

    task automatic test_abort();
        int early_done = 0, busy_n = 0, done_at = -1;
        @(negedge clk);
        start = 1; abort = 0; tick = 1; cfg_data_bits = 8; cfg_parity_en = 0; cfg_stop2 = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            model_step();
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (obs[d] !== expect_of(d)) $display("FAIL abort_model dut%0d c%0d got=%b want=%b", d, c, obs[d], expect_of(d));
                else n_pass++;
            end
            if (c == 18) begin
                n_total++;
                if (obs[1][8:2] !== {3'd2, 4'd3}) $display("FAIL abort_pre_state got=%h want=23", obs[1][8:2]);
                else n_pass++;
            end
            if (c == 19) begin
                n_total++;
                if (obs[1] !== 10'b0) $display("FAIL abort_to_idle got=%b want=0", obs[1]);
                else n_pass++;
            end
            if (c <= 25 && obs[1][0]) early_done++;
            if (c > 25 && c < 190) begin
                if (obs[1][9]) busy_n++;
                if (obs[1][0]) done_at = c;
            end
            if (c == 191) begin
                for (int d = 0; d < 3; d++) begin
                    n_total++;
                    if (obs[d][9] !== 1'b0) $display("FAIL abort_blocks_start dut%0d got=%b want=0", d, obs[d][9]);
                    else n_pass++;
                end
            end
            abort = (c == 18) || (c == 190);
            start = (c == 25) || (c == 190);
        end
        start = 0; abort = 0;
        n_total++; if (early_done !== 0) $display("FAIL abort_no_done got=%0d want=0", early_done); else n_pass++;
        n_total++; if (busy_n !== 40)    $display("FAIL abort_restart_len got=%0d want=40", busy_n); else n_pass++;
        n_total++; if (done_at !== 66)   $display("FAIL abort_restart_done got=%0d want=66", done_at); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int early_done = 0, busy_n = 0, done_at = -1;
        @(negedge clk);
        start = 1; abort = 0; tick = 1; cfg_data_bits = 8; cfg_parity_en = 0; cfg_stop2 = 0;
        for (int c = 1; c <= 215; c++) begin
            @(negedge clk);
            model_step();
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (obs[d] !== expect_of(d)) $display("FAIL rstmid_model dut%0d c%0d got=%b want=%b", d, c, obs[d], expect_of(d));
                else n_pass++;
            end
            if (c == 38) begin
                n_total++;
                if (obs[1][8:6] !== 3'd4) $display("FAIL rstmid_in_stop got=%0d want=4", obs[1][8:6]);
                else n_pass++;
                #2 rst_n = 1'b0;
                model_reset();
                #1;
                for (int d = 0; d < 3; d++) begin
                    n_total++;
                    if (obs[d] !== 10'b0) $display("FAIL rstmid_async dut%0d got=%b want=0", d, obs[d]);
                    else n_pass++;
                end
            end
            if (c <= 45 && obs[1][0]) early_done++;
            if (c > 45) begin
                if (obs[1][9]) busy_n++;
                if (obs[1][0]) done_at = c;
            end
            start = (c == 45);
            if (c == 40) rst_n = 1'b1;
        end
        start = 0;
        n_total++; if (early_done !== 0) $display("FAIL rstmid_no_done got=%0d want=0", early_done); else n_pass++;
        n_total++; if (busy_n !== 40)    $display("FAIL rstmid_restart_len got=%0d want=40", busy_n); else n_pass++;
        n_total++; if (done_at !== 86)   $display("FAIL rstmid_restart_done got=%0d want=86", done_at); else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 1; c <= 2300; c++) begin
            @(negedge clk);
            model_step();
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (obs[d] !== expect_of(d)) $display("FAIL random_model dut%0d c%0d got=%b want=%b", d, c, obs[d], expect_of(d));
                else n_pass++;
            end
            if (c < 2000) begin
                tick          = ($urandom_range(0, 3) != 0);
                start         = ($urandom_range(0, 7) == 0);
                abort         = ($urandom_range(0, 199) == 0);
                cfg_data_bits = 4'($urandom_range(0, 15));
                cfg_parity_en = 1'($urandom_range(0, 1));
                cfg_stop2     = 1'($urandom_range(0, 1));
            end else begin
                tick = 1; start = 0; abort = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e2();
        test_clamp();
        test_slow_tick();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
